// File: rtl/sim_pkg.sv
// Shared types and constants for the simulation controller.
// Holds the controller FSM encoding, the test-exit status encoding,
// the default mailbox address and the mailbox-hit decode.
package sim_pkg;

    // Test-exit status reported to the harness.
    typedef enum logic [2:0] {
        NONE    = 3'd0,
        PASS    = 3'd1,
        FAIL    = 3'd2,
        TIMEOUT = 3'd3,
        HALT    = 3'd4
    } status_t;

    // Controller phases: hold core in reset, let it run, let stores settle, park.
    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        DRAIN      = 2'd2,
        DONE       = 2'd3
    } sim_state_t;

    // Word address of the test-exit mailbox unless overridden.
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

    // A mailbox hit needs a full-word store; partial stores never end a test.
    function automatic logic is_tohost_hit(
        input logic        write,
        input logic [31:0] daddr,
        input logic [3:0]  byte_en,
        input logic [31:0] tohost
    );
        return write && (daddr == tohost) && (byte_en == 4'hF);
    endfunction

endpackage

// File: rtl/sim_ctrl_if.sv
// Snoop view of the core's fetch and data-store buses.
// master: the core side driving the bus; slave: the observer (sim_ctrl).
// Pure observation, no handshake: the controller never stalls the core.
interface sim_ctrl_if;

    logic [31:0] iaddr;
    logic        write;
    logic [31:0] daddr;
    logic [3:0]  byte_en;
    logic [31:0] write_data;

    modport master (
        output iaddr,
        output write,
        output daddr,
        output byte_en,
        output write_data
    );

    modport slave (
        input iaddr,
        input write,
        input daddr,
        input byte_en,
        input write_data
    );

endinterface

// File: rtl/pc_loop_det.sv
// Purpose: flag a core spinning on one fetch address for LOOP_CYCLES consecutive enabled cycles.
// Latency: halt is combinational in the cycle that completes the run; the run counter is registered.
// Backpressure: none; passive snoop of the fetch address.
module pc_loop_det #(
    parameter int unsigned LOOP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] iaddr,
    output logic        halt
);

    localparam logic [31:0] LOOP_LAST = 32'(LOOP_CYCLES - 1);

    logic [31:0] prev_iaddr;
    logic [31:0] loop_cnt;
    logic        same;

    // Last cycle's fetch address; sampled every cycle so the first enabled cycle compares against real history.
    always_ff @(posedge clk) begin
        prev_iaddr <= iaddr;
    end

    assign same = (iaddr == prev_iaddr);

    // Length of the current run of unchanged fetch addresses; any change or leaving RUN restarts it.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            loop_cnt <= '0;
        end else if (!same) begin
            loop_cnt <= '0;
        end else if (loop_cnt != 32'hFFFF_FFFF) begin
            loop_cnt <= loop_cnt + 32'd1;
        end
    end

    // Fires on the cycle whose compare would bring the run to LOOP_CYCLES; a zero length disables it.
    always_comb begin
        halt = (LOOP_CYCLES != 0) && en && same && (loop_cnt == LOOP_LAST);
    end

endmodule

// File: rtl/sim_ctrl.sv
// Purpose: sequence core reset, watch for test end (mailbox, loop, timeout), then request a dump.
// Latency: end event latched on the detecting edge; dump_req pulses DRAIN_CYCLES cycles later.
// Backpressure: none; the core bus is only snooped, never stalled.
module sim_ctrl
    import sim_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
    parameter logic [31:0] PC_START       = 32'h0000_0000,
    parameter int unsigned LOOP_CYCLES    = 16,
    parameter int unsigned DRAIN_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    sim_ctrl_if.slave   core,
    output logic        core_rst,
    output logic [31:0] pc_start,
    output logic [31:0] cycle_count,
    output status_t     status,
    output logic [30:0] exit_code,
    output logic        dump_req,
    output logic        done
);

    localparam logic [31:0] RESET_LAST   = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST   = 32'(DRAIN_CYCLES - 1);

    sim_state_t  state;
    sim_state_t  state_nxt;
    logic [31:0] hold_cnt;
    logic [31:0] drain_cnt;
    logic        tohost_hit;
    logic        loop_halt;
    logic        timeout_hit;
    logic        end_evt;
    status_t     end_status;

    assign pc_start = PC_START;

    assign tohost_hit = is_tohost_hit(core.write, core.daddr, core.byte_en, TOHOST_ADDR);

    // Timeout fires in the RUN cycle that brings cycle_count up to TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == TIMEOUT_LAST);

    pc_loop_det #(
        .LOOP_CYCLES (LOOP_CYCLES)
    ) u_loop_det (
        .clk   (clk),
        .rst   (rst),
        .en    (state == RUN),
        .iaddr (core.iaddr),
        .halt  (loop_halt)
    );

    // Phase register; reset always returns to holding the core in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next phase, end-event arbitration (mailbox > loop > timeout) and per-phase core controls.
    always_comb begin
        state_nxt  = state;
        end_evt    = 1'b0;
        end_status = NONE;
        core_rst   = 1'b1;
        done       = 1'b0;
        case (state)
            RESET_HOLD: begin
                core_rst = 1'b1;
                if (!rst && ((RESET_CYCLES == 0) || (hold_cnt == RESET_LAST))) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                core_rst = 1'b0;
                if (tohost_hit) begin
                    end_evt    = 1'b1;
                    end_status = (core.write_data == 32'd1) ? PASS : FAIL;
                end else if (loop_halt) begin
                    end_evt    = 1'b1;
                    end_status = HALT;
                end else if (timeout_hit) begin
                    end_evt    = 1'b1;
                    end_status = TIMEOUT;
                end
                if (end_evt) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                // Core keeps running so stores already issued can land before the dump.
                core_rst = 1'b0;
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                core_rst = 1'b1;
                done     = 1'b1;
            end
            default: begin
                state_nxt = RESET_HOLD;
            end
        endcase
    end

    // Phase counters, run-cycle count, latched result and the one-shot dump request.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt    <= '0;
            drain_cnt   <= '0;
            cycle_count <= '0;
            status      <= NONE;
            exit_code   <= '0;
            dump_req    <= 1'b0;
        end else begin
            hold_cnt  <= (state == RESET_HOLD) ? hold_cnt + 32'd1 : '0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 32'd1 : '0;
            if ((state == RUN) && (cycle_count != 32'hFFFF_FFFF)) begin
                cycle_count <= cycle_count + 32'd1;
            end
            // Only reachable from RUN, where status is still NONE, so the first result sticks.
            if (end_evt) begin
                status <= end_status;
                if (end_status == FAIL) begin
                    exit_code <= core.write_data[31:1];
                end
            end
            dump_req <= (state_nxt == DONE) && (state != DONE);
        end
    end

endmodule

// File: tb/tb_sim_ctrl.sv
module tb_sim_ctrl;
    import sim_pkg::*;

    localparam int          RESET_CYCLES   = 5;
    localparam int          TIMEOUT_CYCLES = 100;
    localparam int          LOOP_CYCLES    = 16;
    localparam int          DRAIN_CYCLES   = 2;
    localparam logic [31:0] TOHOST         = 32'h0000_1000;
    localparam logic [31:0] PC_START       = 32'h0000_0000;
    // Edges with rst low needed before the core is released.
    localparam int          RUN_ENTRY      = (RESET_CYCLES == 0) ? 1 : RESET_CYCLES;

    localparam int M_PASS      = 0;
    localparam int M_FAIL      = 1;
    localparam int M_TIMEOUT   = 2;
    localparam int M_HALT      = 3;
    localparam int M_NEAR_HALT = 4;
    localparam int M_HALT_PASS = 5;
    localparam int M_RANDOM    = 6;

    typedef struct packed {
        logic        core_rst;
        logic        done;
        logic        dump;
        logic [2:0]  status;
        logic [30:0] exit_code;
        logic [31:0] cc;
    } exp_t;

    typedef struct packed {
        logic [2:0]  status;
        logic [30:0] exit_code;
        logic [31:0] cc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_rst;
    logic [31:0] pc_start;
    logic [31:0] cycle_count;
    status_t     status;
    logic [30:0] exit_code;
    logic        dump_req;
    logic        done;

    sim_ctrl_if bus();

    sim_ctrl #(
        .RESET_CYCLES   (RESET_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TOHOST_ADDR    (TOHOST),
        .PC_START       (PC_START),
        .LOOP_CYCLES    (LOOP_CYCLES),
        .DRAIN_CYCLES   (DRAIN_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core        (bus),
        .core_rst    (core_rst),
        .pc_start    (pc_start),
        .cycle_count (cycle_count),
        .status      (status),
        .exit_code   (exit_code),
        .dump_req    (dump_req),
        .done        (done)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    rec_t end_q[$];

    // Reference model: timeline of one test measured in edges since rst was released.
    int          m_n0      = 0;
    bit          m_ended   = 1'b0;
    int          m_end_n0  = 0;
    int          m_eq      = 0;
    logic [31:0] m_last_ia = '0;
    status_t     m_status  = NONE;
    logic [30:0] m_exit    = '0;
    logic [31:0] m_cc      = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_end(input status_t st, input logic [30:0] code);
        rec_t r;
        m_status = st;
        m_exit   = code;
        m_ended  = 1'b1;
        m_end_n0 = m_n0 + 1;
        r.status    = st;
        r.exit_code = code;
        r.cc        = m_cc;
        end_q.push_back(r);
    endtask

    // Drive one cycle of inputs, let the edge happen, and queue the expected post-edge outputs.
    task automatic step(input logic r, input logic [31:0] ia, input logic w, input logic [31:0] da,
                        input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        int   k;
        rst            = r;
        bus.iaddr      = ia;
        bus.write      = w;
        bus.daddr      = da;
        bus.byte_en    = be;
        bus.write_data = wd;
        @(posedge clk);
        if (r) begin
            // A result whose dump never got out is abandoned by the reset.
            if (m_ended && (m_n0 < m_end_n0 + DRAIN_CYCLES) && (end_q.size() != 0))
                end_q.delete(end_q.size() - 1);
            m_n0 = 0; m_ended = 1'b0; m_end_n0 = 0; m_eq = 0;
            m_status = NONE; m_exit = '0; m_cc = '0;
        end else begin
            if (!m_ended && (m_n0 >= RUN_ENTRY)) begin
                k    = m_n0 - RUN_ENTRY + 1;
                m_cc = k;
                m_eq = (ia == m_last_ia) ? m_eq + 1 : 0;
                if (w && (da == TOHOST) && (be == 4'hF))
                    model_end((wd == 32'd1) ? PASS : FAIL, (wd == 32'd1) ? 31'd0 : wd[31:1]);
                else if (m_eq == LOOP_CYCLES)
                    model_end(HALT, '0);
                else if (k == TIMEOUT_CYCLES)
                    model_end(TIMEOUT, '0);
            end
            m_n0++;
        end
        m_last_ia   = ia;
        e.core_rst  = r || (m_n0 < RUN_ENTRY) || (m_ended && (m_n0 >= m_end_n0 + DRAIN_CYCLES));
        e.done      = !r && m_ended && (m_n0 >= m_end_n0 + DRAIN_CYCLES);
        e.dump      = !r && m_ended && (m_n0 == m_end_n0 + DRAIN_CYCLES);
        e.status    = m_status;
        e.exit_code = m_exit;
        e.cc        = m_cc;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: per-cycle outputs against the queued expectation, and each dump against the queued result.
    initial begin
        exp_t e;
        rec_t r;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("core_rst", core_rst, e.core_rst);
                chk("done", done, e.done);
                chk("dump_req", dump_req, e.dump);
                chk("status", status, e.status);
                chk("exit_code", exit_code, e.exit_code);
                chk("cycle_count", cycle_count, e.cc);
                chk("pc_start", pc_start, PC_START);
            end
            if (dump_req) begin
                if (end_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dump_unexpected: got dump_req=1, want no dump at %0t", $time);
                end else begin
                    r = end_q.pop_front();
                    chk("dump_status", status, r.status);
                    chk("dump_exit_code", exit_code, r.exit_code);
                    chk("dump_cycle_count", cycle_count, r.cc);
                end
            end
        end
    end

    // One test run: reset, scripted or random core activity, optional reset mid-run or mid-drain.
    task automatic episode(input int mode, input int pk, input bit abort_drain, input int abort_run);
        logic [31:0] ia = 32'h100;
        logic        w;
        logic [31:0] da;
        logic [31:0] wd;
        logic [3:0]  be;
        int          k;
        int          hold_left = 0;
        for (int i = 0; i < 3; i++) begin
            ia = ia + 32'd4;
            step(1'b1, ia, 1'b0, '0, '0, '0);
        end
        for (int guard = 0; guard < 300; guard++) begin
            if (m_ended && (m_n0 >= m_end_n0 + DRAIN_CYCLES + 3)) break;
            k  = (!m_ended && (m_n0 >= RUN_ENTRY)) ? (m_n0 - RUN_ENTRY + 1) : 0;
            if ((abort_run != 0) && (k == abort_run)) return;
            if (abort_drain && m_ended && (m_n0 == m_end_n0 + 1)) return;
            w  = 1'b0;
            da = $urandom;
            be = 4'($urandom);
            wd = $urandom;
            case (mode)
                M_PASS: begin
                    ia = ia + 32'd4;
                    if (k == pk) begin w = 1'b1; da = TOHOST; be = 4'hF; wd = 32'd1; end
                end
                M_FAIL: begin
                    ia = ia + 32'd4;
                    if (k == pk - 5) begin w = 1'b1; da = TOHOST; be = 4'h1; wd = 32'd1; end
                    if (k == pk) begin w = 1'b1; da = TOHOST; be = 4'hF; wd = 32'd7; end
                end
                M_TIMEOUT: ia = ia + 32'd4;
                M_HALT, M_HALT_PASS: begin
                    ia = ((k != 0) && (k >= pk)) ? 32'h40 : ia + 32'd4;
                    if ((mode == M_HALT_PASS) && (k == pk + LOOP_CYCLES)) begin
                        w = 1'b1; da = TOHOST; be = 4'hF; wd = 32'd1;
                    end
                end
                M_NEAR_HALT: ia = ((k >= pk) && (k < pk + LOOP_CYCLES)) ? 32'h40 : ia + 32'd4;
                default: begin
                    if (hold_left > 0) hold_left--;
                    else begin
                        ia = ia + 32'd4;
                        if ($urandom_range(0, 19) == 0) hold_left = $urandom_range(5, 20);
                    end
                    if ($urandom_range(0, 29) == 0) begin
                        w  = 1'b1;
                        da = ($urandom_range(0, 1) == 1) ? TOHOST : (TOHOST ^ (32'h1 << $urandom_range(0, 31)));
                        be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
                        wd = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom;
                    end
                end
            endcase
            // Mailbox stores after the end must not disturb the latched result.
            if (m_ended) begin
                w  = 1'b1; da = TOHOST; be = 4'hF;
                wd = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
            end
            step(1'b0, ia, w, da, be, wd);
        end
    endtask

    initial begin
        episode(M_PASS, 20, 1'b0, 0);
        episode(M_FAIL, 12, 1'b0, 0);
        episode(M_TIMEOUT, 0, 1'b0, 0);
        episode(M_PASS, TIMEOUT_CYCLES, 1'b0, 0);
        episode(M_HALT, 10, 1'b0, 0);
        episode(M_NEAR_HALT, 30, 1'b0, 0);
        episode(M_HALT_PASS, 7, 1'b0, 0);
        episode(M_HALT, TIMEOUT_CYCLES - LOOP_CYCLES, 1'b0, 0);
        episode(M_PASS, 15, 1'b1, 0);
        episode(M_TIMEOUT, 0, 1'b0, 40);
        for (int i = 0; i < 12; i++) begin
            episode(M_RANDOM, 0, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 90)) : 0);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 1'b0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("leftover_results", end_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_ctrl.md
SIM_CTRL -- requirements
Module: sim_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 5: cycles core_rst stays high after rst falls.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100: RUN cycles before timeout; 0 disables timeout.
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000: word address of the test-exit mailbox.
REQ-004 SHALL have parameter PC_START, default 32'h0000_0000: value driven on pc_start.
REQ-005 SHALL have parameter LOOP_CYCLES, default 16: consecutive unchanged iaddr cycles that mean halt; 0 disables.
REQ-006 SHALL have parameter DRAIN_CYCLES, default 2: cycles between end detection and dump_req.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 iaddr  input  32  core fetch address, snooped.
REQ-010 write  input  1  core data-store strobe, snooped.
REQ-011 daddr  input  32  core data address, snooped.
REQ-012 byte_en  input  4  core store byte enables, snooped.
REQ-013 write_data  input  32  core store data, snooped.
REQ-014 core_rst  output  1  synchronous active-high reset to core.
REQ-015 pc_start  output  32  boot PC to core.
REQ-016 cycle_count  output  32  RUN cycles elapsed, saturating.
REQ-017 status  output  3  status_t: NONE, PASS, FAIL, TIMEOUT, HALT.
REQ-018 exit_code  output  31  write_data[31:1] of a failing tohost store.
REQ-019 dump_req  output  1  one-cycle pulse requesting memory dump and finish.
REQ-020 done  output  1  high in DONE state.

Function
REQ-021 FSM states SHALL be RESET_HOLD, RUN, DRAIN, DONE.
REQ-022 RESET_HOLD: core_rst=1; internal counter increments while rst=0; enter RUN after RESET_CYCLES such cycles (RESET_CYCLES=0: enter RUN on first cycle with rst=0).
REQ-023 RUN: core_rst=0; cycle_count increments by 1 per cycle, saturating at 32'hFFFF_FFFF.
REQ-024 Tohost hit SHALL be write=1 && daddr==TOHOST_ADDR && byte_en==4'hF; partial-byte stores to TOHOST_ADDR are ignored.
REQ-025 Tohost hit in RUN with write_data==1 SHALL set status=PASS; any other value SHALL set status=FAIL and exit_code=write_data[31:1]; next state DRAIN.
REQ-026 If TIMEOUT_CYCLES!=0 and cycle_count reaches TIMEOUT_CYCLES with no tohost hit, status=TIMEOUT, next state DRAIN.
REQ-027 If LOOP_CYCLES!=0 and iaddr equals its previous-cycle value for LOOP_CYCLES consecutive RUN cycles, status=HALT, next state DRAIN; any iaddr change clears the loop counter.
REQ-028 Simultaneous end events SHALL resolve by priority tohost > HALT > TIMEOUT; only one status is latched.
REQ-029 DRAIN: core_rst=0 (outstanding stores land); cycle_count frozen; after DRAIN_CYCLES cycles enter DONE.
REQ-030 dump_req SHALL pulse high for exactly the first cycle in DONE.
REQ-031 DONE: core_rst=1, done=1; status, exit_code, cycle_count hold; tohost stores ignored; remain until rst.
REQ-032 Status, once non-NONE, SHALL never change until rst.
REQ-033 pc_start SHALL equal PC_START constantly, including during reset.

Reset
REQ-034 rst=1 in any state SHALL, next edge, enter RESET_HOLD and set core_rst=1, cycle_count=0, status=NONE, exit_code=0, dump_req=0, done=0, and clear all internal counters.
REQ-035 rst asserted mid-RUN or mid-DRAIN SHALL discard pending end events; no dump_req is emitted.

Structure
REQ-036 status_t and sim_state_t enums SHALL live in shared package sim_pkg; TOHOST_ADDR default constant also there.
REQ-037 Loop detector (iaddr compare plus counter) SHALL be sub-module pc_loop_det; all else in sim_ctrl.

Verification
REQ-038 rst high 3 cycles then low, RESET_CYCLES=5 -> core_rst falls exactly 5 cycles after rst falls; cycle_count=0 at that edge.
REQ-039 In RUN cycle 20, store 32'h1 to 32'h1000, byte_en=4'hF -> status=PASS, dump_req pulses 2 cycles later, done=1, cycle_count=20.
REQ-040 Store 32'h0000_0007 to TOHOST -> status=FAIL, exit_code=3; earlier store byte_en=4'h1 to same address -> ignored.
REQ-041 No store, iaddr incrementing, TIMEOUT_CYCLES=100 -> status=TIMEOUT at cycle_count=100; same-cycle tohost PASS store -> PASS wins.
REQ-042 iaddr held at 32'h40 for 16 cycles -> status=HALT; held 15 cycles then changed -> no HALT.
REQ-043 rst asserted during DRAIN -> RESET_HOLD, status=NONE, no dump_req pulse.
